// File: rtl/case_3_mul_share_sched.sv
// case_3_mul_share_sched
//
// Time-shares one signed DIN0_WIDTH x DIN1_WIDTH multiplier between NUM_REQ
// requesters. A round-robin arbiter grants at most one requester per cycle.
// The granted operands are multiplied and registered into a single result
// slot. Each result is tagged with the requester id and carries a flag that
// is set when the product does not fit in DOUT_WIDTH signed bits.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous reset, active-high
//   req_valid  in   [NUM_REQ]              per-requester operand valid
//   req_ready  out  [NUM_REQ]              per-requester accept (one-hot or zero)
//   req_din0   in   [NUM_REQ*DIN0_WIDTH]   packed operand A, requester i at [i*DIN0_WIDTH +: DIN0_WIDTH]
//   req_din1   in   [NUM_REQ*DIN1_WIDTH]   packed operand B, same packing
//   rsp_valid  out  result slot holds a valid result
//   rsp_ready  in   consumer accepts the result
//   rsp_dout   out  [DOUT_WIDTH]           truncated signed product
//   rsp_id     out  [ID_WIDTH]             requester that issued the result
//   rsp_ovf    out  full product does not fit in DOUT_WIDTH signed bits
//   busy       out  rsp_valid OR any req_valid
//   issue_cnt  out  [CNT_WIDTH]            accepted operations, wraps
module case_3_mul_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 6,
  parameter int DIN1_WIDTH = 4,
  parameter int DOUT_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic                             rsp_ovf,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             issue_cnt
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  // Registered state
  logic                   rsp_valid_reg, rsp_valid_next;
  logic [DOUT_WIDTH-1:0]  rsp_dout_reg,  rsp_dout_next;
  logic [ID_WIDTH-1:0]    rsp_id_reg,    rsp_id_next;
  logic                   rsp_ovf_reg,   rsp_ovf_next;
  logic [ID_WIDTH-1:0]    rr_ptr_reg,    rr_ptr_next;
  logic [CNT_WIDTH-1:0]   issue_cnt_reg, issue_cnt_next;

  // Unpacked per-requester operand views
  logic signed [DIN0_WIDTH-1:0] op_a [NUM_REQ];
  logic signed [DIN1_WIDTH-1:0] op_b [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_a[gi] = req_din0[gi*DIN0_WIDTH +: DIN0_WIDTH];
      assign op_b[gi] = req_din1[gi*DIN1_WIDTH +: DIN1_WIDTH];
    end
  endgenerate

  // Round-robin grant: first valid requester at or after rr_ptr, wrapping.
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH:0]   idx_wide;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_wide    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_wide = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(k);
      if (idx_wide >= (ID_WIDTH+1)'(NUM_REQ)) begin
        idx_wide = idx_wide - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[idx_wide[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_wide[ID_WIDTH-1:0];
      end
    end
  end

  // The slot can take a new result when it is empty or being drained now.
  // Reset blocks acceptance so nothing is handed out during reset.
  logic slot_free;
  logic accept;

  assign slot_free = !rsp_valid_reg || rsp_ready;
  assign accept    = grant_found && slot_free && !ap_rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_idx == ID_WIDTH'(gi));
    end
  endgenerate

  // The single shared multiplier, fed by the grant mux.
  logic signed [DIN0_WIDTH-1:0] sel_a;
  logic signed [DIN1_WIDTH-1:0] sel_b;
  logic signed [PROD_WIDTH-1:0] prod_full;
  logic        [DOUT_WIDTH-1:0] prod_trunc;
  logic                         prod_ovf;

  assign sel_a      = op_a[grant_idx];
  assign sel_b      = op_b[grant_idx];
  assign prod_full  = PROD_WIDTH'(sel_a) * PROD_WIDTH'(sel_b);
  assign prod_trunc = prod_full[DOUT_WIDTH-1:0];
  // Overflow when sign-extending the kept bits does not reproduce the product.
  assign prod_ovf   = (prod_full != PROD_WIDTH'($signed(prod_trunc)));

  // Next-state logic
  always_comb begin
    rsp_valid_next = rsp_valid_reg;
    rsp_dout_next  = rsp_dout_reg;
    rsp_id_next    = rsp_id_reg;
    rsp_ovf_next   = rsp_ovf_reg;
    rr_ptr_next    = rr_ptr_reg;
    issue_cnt_next = issue_cnt_reg;
    if (accept) begin
      // A new result overwrites whatever is being drained this cycle.
      rsp_valid_next = 1'b1;
      rsp_dout_next  = prod_trunc;
      rsp_id_next    = grant_idx;
      rsp_ovf_next   = prod_ovf;
      rr_ptr_next    = (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      issue_cnt_next = issue_cnt_reg + CNT_WIDTH'(1);
    end else if (rsp_ready) begin
      // Drain only; payload fields keep their last values.
      rsp_valid_next = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_dout_reg  <= '0;
      rsp_id_reg    <= '0;
      rsp_ovf_reg   <= 1'b0;
      rr_ptr_reg    <= '0;
      issue_cnt_reg <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_dout_reg  <= rsp_dout_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_ovf_reg   <= rsp_ovf_next;
      rr_ptr_reg    <= rr_ptr_next;
      issue_cnt_reg <= issue_cnt_next;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_dout  = rsp_dout_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_ovf   = rsp_ovf_reg;
  assign issue_cnt = issue_cnt_reg;
  assign busy      = rsp_valid_reg || (|req_valid);

endmodule

// File: tb/tb_case_3_mul_share_sched.sv
`timescale 1ns/1ps
module tb_case_3_mul_share_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_din0;
  logic [15:0] req_din1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_dout;
  logic [1:0]  rsp_id;
  logic        rsp_ovf;
  logic        busy;
  logic [15:0] issue_cnt;

  int checks = 0;
  int errors = 0;

  case_3_mul_share_sched dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b0; req_din0 = '0; req_din1 = '0;
    repeat (3) step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_dout !== 8'h00) begin errors++; $display("FAIL reset_rsp_dout: got %h want 00", rsp_dout); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf: got %b want 0", rsp_ovf); end
    checks++; if (issue_cnt !== 16'h0000) begin errors++; $display("FAIL reset_issue_cnt: got %h want 0000", issue_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready_idle: got %h want 0", req_ready); end
    req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready_held: got %h want 0", req_ready); end
    step();
    checks++; if (issue_cnt !== 16'h0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_no_issue: cnt %h valid %b want 0000 0", issue_cnt, rsp_valid); end
    req_valid = 4'h0; ap_rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    req_din0[5:0] = 6'h3B;   // -5
    req_din1[3:0] = 4'h3;    // 3
    req_valid = 4'h1; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h1) begin errors++; $display("FAIL basic_req_ready: got %h want 1", req_ready); end
    step();
    req_valid = 4'h0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_dout !== 8'hF1) begin errors++; $display("FAIL basic_rsp_dout: got %h want f1", rsp_dout); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL basic_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL basic_rsp_ovf: got %b want 0", rsp_ovf); end
    checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL basic_issue_cnt: got %0d want 1", issue_cnt); end
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_dout !== 8'hF1) begin errors++; $display("FAIL basic_drain: valid %b dout %h want 0 f1", rsp_valid, rsp_dout); end
    $display("test_basic done: -5*3 -> f1");
  endtask

  task automatic test_overflow();
    req_din0[17:12] = 6'h20; // -32
    req_din1[11:8]  = 4'h8;  // -8
    req_valid = 4'h4;
    step();
    checks++; if (rsp_dout !== 8'h00 || rsp_ovf !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL ovf_neg: dout %h ovf %b id %0d want 00 1 2", rsp_dout, rsp_ovf, rsp_id); end
    checks++; if (issue_cnt !== 16'd2) begin errors++; $display("FAIL ovf_neg_cnt: got %0d want 2", issue_cnt); end
    req_din0[17:12] = 6'h1F; // 31
    req_din1[11:8]  = 4'h7;  // 7
    step();
    req_valid = 4'h0;
    checks++; if (rsp_dout !== 8'hD9 || rsp_ovf !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL ovf_pos: dout %h ovf %b id %0d want d9 1 2", rsp_dout, rsp_ovf, rsp_id); end
    checks++; if (issue_cnt !== 16'd3) begin errors++; $display("FAIL ovf_pos_cnt: got %0d want 3", issue_cnt); end
    step();
    $display("test_overflow done");
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_dout [4];
    exp_dout[0] = 8'd2; exp_dout[1] = 8'd6; exp_dout[2] = 8'd12; exp_dout[3] = 8'd20;
    ap_rst = 1'b1; step(); ap_rst = 1'b0;
    // requester i: din0 = i+1, din1 = i+2
    req_din0 = {6'd4, 6'd3, 6'd2, 6'd1};
    req_din1 = {4'd5, 4'd4, 4'd3, 4'd2};
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== (4'h1 << (k % 4))) begin errors++; $display("FAIL rr_req_ready[%0d]: got %h want %h", k, req_ready, 4'h1 << (k % 4)); end
      step();
      checks++; if (rsp_id !== 2'(k % 4) || rsp_dout !== exp_dout[k % 4] || rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp[%0d]: id %0d dout %0d valid %b want %0d %0d 1", k, rsp_id, rsp_dout, rsp_valid, k % 4, exp_dout[k % 4]); end
      $display("rr op %0d: id %0d dout %0d", k, rsp_id, rsp_dout);
    end
    req_valid = 4'h0;
    checks++; if (issue_cnt !== 16'd8) begin errors++; $display("FAIL rr_issue_cnt: got %0d want 8", issue_cnt); end
    step();
  endtask

  task automatic test_backpressure();
    req_din0[5:0]  = 6'd10;  // req0: 10 * -2 = -20 -> ec
    req_din1[3:0]  = 4'hE;
    req_din0[11:6] = 6'h39;  // req1: -7 * 6 = -42 -> d6
    req_din1[7:4]  = 4'd6;
    req_valid = 4'h3; rsp_ready = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_dout !== 8'hEC || rsp_id !== 2'd0 || issue_cnt !== 16'd9) begin errors++; $display("FAIL bp_first: valid %b dout %h id %0d cnt %0d want 1 ec 0 9", rsp_valid, rsp_dout, rsp_id, issue_cnt); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %h want 0", k, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_dout !== 8'hEC || rsp_id !== 2'd0 || rsp_ovf !== 1'b0 || issue_cnt !== 16'd9) begin errors++; $display("FAIL bp_hold[%0d]: valid %b dout %h id %0d ovf %b cnt %0d", k, rsp_valid, rsp_dout, rsp_id, rsp_ovf, issue_cnt); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h2) begin errors++; $display("FAIL bp_release_ready: got %h want 2", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_dout !== 8'hD6 || rsp_id !== 2'd1 || issue_cnt !== 16'd10) begin errors++; $display("FAIL bp_after1: valid %b dout %h id %0d cnt %0d want 1 d6 1 10", rsp_valid, rsp_dout, rsp_id, issue_cnt); end
    step();
    req_valid = 4'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_dout !== 8'hEC || rsp_id !== 2'd0 || issue_cnt !== 16'd11) begin errors++; $display("FAIL bp_after2: valid %b dout %h id %0d cnt %0d want 1 ec 0 11", rsp_valid, rsp_dout, rsp_id, issue_cnt); end
    step();
    checks++; if (rsp_valid !== 1'b0 || issue_cnt !== 16'd11) begin errors++; $display("FAIL bp_drain: valid %b cnt %0d want 0 11", rsp_valid, issue_cnt); end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_pending_and_wrap();
    req_din0[11:6] = 6'd5;
    req_din1[7:4]  = 4'd5;
    req_valid = 4'h2; rsp_ready = 1'b0;
    step();
    req_valid = 4'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_dout !== 8'h19 || rsp_id !== 2'd1) begin errors++; $display("FAIL pend_setup: valid %b dout %h id %0d want 1 19 1", rsp_valid, rsp_dout, rsp_id); end
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0; rsp_ready = 1'b1;
    checks++; if (rsp_valid !== 1'b0 || rsp_dout !== 8'h00 || rsp_id !== 2'd0 || issue_cnt !== 16'd0) begin errors++; $display("FAIL pend_reset: valid %b dout %h id %0d cnt %0d want 0 00 0 0", rsp_valid, rsp_dout, rsp_id, issue_cnt); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pend_discard: valid %b want 0", rsp_valid); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'h1) begin errors++; $display("FAIL pend_rr_ptr: req_ready %h want 1", req_ready); end
    req_valid = 4'h1;
    for (int k = 0; k < 65535; k++) step();
    checks++; if (issue_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", issue_cnt); end
    step();
    req_valid = 4'h0;
    checks++; if (issue_cnt !== 16'h0000 || rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap: cnt %h valid %b want 0000 1", issue_cnt, rsp_valid); end
    $display("test_reset_pending_and_wrap done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_pending_and_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
